// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: per-requester request fields (packed
// slice i per requester), one-hot accept, and the tagged result strobe.
interface alu_arbiter_if #(
  parameter int NREQ          = 2,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0]               req_ready;
  logic [NREQ*ADDRESS_WIDTH-1:0] req_rs1;
  logic [NREQ*ADDRESS_WIDTH-1:0] req_rs2;
  logic [NREQ*ADDRESS_WIDTH-1:0] req_rd;
  logic [NREQ*DATA_WIDTH-1:0]    req_imm;
  logic [NREQ-1:0]               req_alusrc;
  logic [NREQ-1:0]               req_aluctrl;
  logic [NREQ-1:0]               req_we;
  logic                          resp_valid;
  logic [IDW-1:0]                resp_id;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_imm,
           req_alusrc, req_aluctrl, req_we,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_imm,
           req_alusrc, req_aluctrl, req_we,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU/register-file datapath between
// NREQ requesters. IDLE -> EXEC -> RESP per operation.
// Optional macro ALU_ARB_FASTPATH_EN: RESP also arbitrates, allowing
// back-to-back operations every 2 cycles instead of 3.
module alu_arbiter #(
  parameter int NREQ          = 2,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_arbiter_if.slave             bus,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic                     ALUctrl,
  output logic [DATA_WIDTH-1:0]    immOp,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]    ALUout
);
  localparam int          IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [IDW-1:0]           rr_ptr;
  logic                     found;
  logic [IDW-1:0]           win_id;
  logic                     grant;

  logic [IDW-1:0]           lat_id;
  logic [ADDRESS_WIDTH-1:0] lat_rs1;
  logic [ADDRESS_WIDTH-1:0] lat_rs2;
  logic [ADDRESS_WIDTH-1:0] lat_rd;
  logic [DATA_WIDTH-1:0]    lat_imm;
  logic                     lat_alusrc;
  logic                     lat_aluctrl;
  logic                     lat_we;

  logic [IDW-1:0]           resp_id_q;
  logic [DATA_WIDTH-1:0]    resp_data_q;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IDW'(sum % NREQ_U);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int unsigned off = 0; off < NREQ_U; off++) begin
      if (!found && bus.req_valid[wrap_idx(rr_ptr, off)]) begin
        found  = 1'b1;
        win_id = wrap_idx(rr_ptr, off);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, grant decision and one-hot accept.
  always_comb begin
    state_nxt     = state;
    grant         = 1'b0;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
`ifdef ALU_ARB_FASTPATH_EN
        if (found) begin
          grant     = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) bus.req_ready[win_id] = 1'b1;
  end

  // Capture the winner's fields and id at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_id      <= '0;
      lat_rs1     <= '0;
      lat_rs2     <= '0;
      lat_rd      <= '0;
      lat_imm     <= '0;
      lat_alusrc  <= 1'b0;
      lat_aluctrl <= 1'b0;
      lat_we      <= 1'b0;
    end else if (grant) begin
      lat_id      <= win_id;
      lat_rs1     <= bus.req_rs1[32'(win_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      lat_rs2     <= bus.req_rs2[32'(win_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      lat_rd      <= bus.req_rd[32'(win_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      lat_imm     <= bus.req_imm[32'(win_id)*DATA_WIDTH +: DATA_WIDTH];
      lat_alusrc  <= bus.req_alusrc[win_id];
      lat_aluctrl <= bus.req_aluctrl[win_id];
      lat_we      <= bus.req_we[win_id];
    end
  end

  // At the end of EXEC: capture the result, tag it, advance the RR pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
    end else if (state == EXEC) begin
      resp_id_q   <= lat_id;
      resp_data_q <= ALUout;
      rr_ptr      <= (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + 1'b1;
    end
  end

  // Datapath controls are live only during EXEC; rd 0 is never written.
  always_comb begin
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    ALUctrl  = 1'b0;
    immOp    = '0;
    rs1      = '0;
    rs2      = '0;
    rd       = '0;
    if (state == EXEC) begin
      RegWrite = lat_we && (lat_rd != '0);
      ALUsrc   = lat_alusrc;
      ALUctrl  = lat_aluctrl;
      immOp    = lat_imm;
      rs1      = lat_rs1;
      rs2      = lat_rs2;
      rd       = lat_rd;
    end
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (2 requesters, 5-bit addresses, 32-bit data).
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef ALU_ARB_FASTPATH_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          RegWrite, ALUsrc, ALUctrl;
  logic [DW-1:0] immOp;
  logic [AW-1:0] rs1, rs2, rd;
  logic [DW-1:0] ALUout;
  logic          alu_model = 1'b0;
  logic [DW-1:0] alu_val = '0;

  int checks = 0;
  int failures = 0;

  alu_arbiter_if #(.NREQ(NREQ), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .immOp(immOp),
    .rs1(rs1), .rs2(rs2), .rd(rd), .ALUout(ALUout)
  );

  // Datapath stand-in: either a fixed value or immOp + 1.
  assign ALUout = alu_model ? immOp + 32'd1 : alu_val;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] ad,
                         input logic [DW-1:0] imm, input logic src,
                         input logic ctl, input logic we);
    bus.req_valid[i]         = v;
    bus.req_rs1[i*AW +: AW]  = a1;
    bus.req_rs2[i*AW +: AW]  = a2;
    bus.req_rd[i*AW +: AW]   = ad;
    bus.req_imm[i*DW +: DW]  = imm;
    bus.req_alusrc[i]        = src;
    bus.req_aluctrl[i]       = ctl;
    bus.req_we[i]            = we;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd = '0;
    bus.req_imm = '0; bus.req_alusrc = '0; bus.req_aluctrl = '0; bus.req_we = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_id !== 1'b0) begin failures++; $display("FAIL reset_resp_id got=%0d exp=0", bus.resp_id); end
    checks++; if (bus.resp_data !== 32'd0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data); end
    checks++; if ({RegWrite, ALUsrc, ALUctrl, immOp, rs1, rs2, rd} !== '0) begin failures++; $display("FAIL reset_datapath got nonzero (RegWrite=%b immOp=%h)", RegWrite, immOp); end
  endtask

  task automatic test_basic;
    do_reset;
    alu_model = 1'b0; alu_val = 32'hA;
    set_req(0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL basic_accept got=%b exp=01", bus.req_ready); end
    next_cycle;
    bus.req_valid[0] = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL basic_regwrite got=%b exp=1", RegWrite); end
    checks++; if ({ALUsrc, ALUctrl} !== 2'b10) begin failures++; $display("FAIL basic_src_ctl got=%b exp=10", {ALUsrc, ALUctrl}); end
    checks++; if ({rs1, rs2, rd} !== {5'd1, 5'd2, 5'd3}) begin failures++; $display("FAIL basic_addr got=%0d/%0d/%0d exp=1/2/3", rs1, rs2, rd); end
    checks++; if (immOp !== 32'd5) begin failures++; $display("FAIL basic_imm got=%h exp=5", immOp); end
    checks++; if (bus.req_ready !== 2'b00 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL basic_exec_quiet ready=%b resp_valid=%b exp=00/0", bus.req_ready, bus.resp_valid); end
    next_cycle;
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL basic_resp_valid got=%b exp=1", bus.resp_valid); end
    checks++; if (bus.resp_id !== 1'b0) begin failures++; $display("FAIL basic_resp_id got=%0d exp=0", bus.resp_id); end
    checks++; if (bus.resp_data !== 32'hA) begin failures++; $display("FAIL basic_resp_data got=%h exp=a", bus.resp_data); end
    checks++; if (RegWrite !== 1'b0 || immOp !== 32'd0) begin failures++; $display("FAIL basic_resp_dp_off RegWrite=%b immOp=%h exp=0/0", RegWrite, immOp); end
    next_cycle;
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL basic_resp_pulse got=%b exp=0", bus.resp_valid); end
  endtask

  task automatic test_round_robin;
    int n;
    int e;
    do_reset;
    alu_model = 1'b1;
    set_req(0, 1'b1, 5'd4, 5'd0, 5'd8, 32'h10, 1'b1, 1'b0, 1'b1);
    set_req(1, 1'b1, 5'd7, 5'd0, 5'd9, 32'h20, 1'b1, 1'b0, 1'b1);
    #1;
    for (int k = 0; k < 4; k++) begin
      e = k % 2;
      n = 0;
      while (bus.req_ready === 2'b00 && n < 10) begin next_cycle; n++; end
      checks++; if (bus.req_ready !== ((e == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_grant op=%0d got=%b exp_id=%0d", k, bus.req_ready, e); end
      next_cycle;
      checks++; if (rs1 !== ((e == 1) ? 5'd7 : 5'd4)) begin failures++; $display("FAIL rr_exec_rs1 op=%0d got=%0d exp=%0d", k, rs1, (e == 1) ? 7 : 4); end
      next_cycle;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'(e)) begin failures++; $display("FAIL rr_resp op=%0d valid=%b id=%0d exp=1/%0d", k, bus.resp_valid, bus.resp_id, e); end
      checks++; if (bus.resp_data !== ((e == 1) ? 32'h21 : 32'h11)) begin failures++; $display("FAIL rr_data op=%0d got=%h exp=%h", k, bus.resp_data, (e == 1) ? 32'h21 : 32'h11); end
    end
    bus.req_valid = '0;
    repeat (3) next_cycle;
  endtask

  task automatic test_rd_zero;
    do_reset;
    alu_model = 1'b0; alu_val = 32'h55;
    set_req(1, 1'b1, 5'd9, 5'd1, 5'd0, 32'h77, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL rd0_accept got=%b exp=10", bus.req_ready); end
    next_cycle;
    bus.req_valid[1] = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL rd0_regwrite got=%b exp=0", RegWrite); end
    checks++; if ({ALUsrc, ALUctrl, rs1, immOp} !== {1'b0, 1'b1, 5'd9, 32'h77}) begin failures++; $display("FAIL rd0_exec src=%b ctl=%b rs1=%0d imm=%h exp=0/1/9/77", ALUsrc, ALUctrl, rs1, immOp); end
    next_cycle;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_data !== 32'h55) begin failures++; $display("FAIL rd0_resp valid=%b id=%0d data=%h exp=1/1/55", bus.resp_valid, bus.resp_id, bus.resp_data); end
    next_cycle;
  endtask

  task automatic test_reset_mid_exec;
    do_reset;
    alu_model = 1'b0; alu_val = 32'h33;
    set_req(0, 1'b1, 5'd1, 5'd1, 5'd2, 32'd1, 1'b0, 1'b0, 1'b1);
    next_cycle; bus.req_valid[0] = 1'b0;
    next_cycle; next_cycle;
    set_req(1, 1'b1, 5'd3, 5'd3, 5'd6, 32'd2, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL rst_exec_accept got=%b exp=10", bus.req_ready); end
    next_cycle;
    bus.req_valid[1] = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL rst_exec_pre got=%b exp=1", RegWrite); end
    rst_n = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0 || rd !== 5'd0) begin failures++; $display("FAIL rst_exec_async RegWrite=%b rd=%0d exp=0/0", RegWrite, rd); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_exec_noresp got=%b exp=0", bus.resp_valid); end
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(0, 1'b1, 5'd1, 5'd1, 5'd2, 32'd1, 1'b0, 1'b0, 1'b1);
    set_req(1, 1'b1, 5'd3, 5'd3, 5'd6, 32'd2, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rst_exec_rrptr got=%b exp=01", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'd0) begin failures++; $display("FAIL rst_exec_after valid=%b data=%h exp=0/0", bus.resp_valid, bus.resp_data); end
    next_cycle;
    bus.req_valid = '0;
    next_cycle;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_data !== 32'h33) begin failures++; $display("FAIL rst_exec_next valid=%b id=%0d data=%h exp=1/0/33", bus.resp_valid, bus.resp_id, bus.resp_data); end
    next_cycle;
  endtask

  task automatic test_withdraw;
    int bad;
    do_reset;
    alu_model = 1'b0; alu_val = 32'h66;
    set_req(1, 1'b1, 5'd5, 5'd5, 5'd5, 32'd3, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL wd_accept got=%b exp=10", bus.req_ready); end
    next_cycle;
    bus.req_valid[1] = 1'b0;
    set_req(0, 1'b1, 5'd2, 5'd2, 5'd2, 32'd4, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL wd_busy_ready got=%b exp=00", bus.req_ready); end
    #2 bus.req_valid[0] = 1'b0;
    next_cycle;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.req_ready !== 2'b00) begin failures++; $display("FAIL wd_resp valid=%b id=%0d ready=%b exp=1/1/00", bus.resp_valid, bus.resp_id, bus.req_ready); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      next_cycle;
      if (bus.req_ready !== 2'b00 || bus.resp_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL wd_never_granted bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back;
    int n;
    int gap;
    do_reset;
    alu_model = 1'b1;
    set_req(0, 1'b1, 5'd1, 5'd1, 5'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    set_req(1, 1'b1, 5'd2, 5'd2, 5'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin next_cycle; n++; end
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b exp=1 within 20 cycles", bus.resp_valid); end
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      do begin next_cycle; gap++; end while (bus.resp_valid !== 1'b1 && gap < 20);
      checks++; if (gap !== EXP_GAP) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", k, gap, EXP_GAP); end
    end
    bus.req_valid = '0;
    repeat (3) next_cycle;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_rd_zero;
    test_reset_mid_exec;
    test_withdraw;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
